// File: rtl/fib_sequencer_pkg.sv
// Shared definitions for the recursive Fibonacci sequencer: FSM encoding and
// default parameter values.
package fib_sequencer_pkg;

    localparam int N_W_DEF   = 8;
    localparam int RES_W_DEF = 16;
    localparam int CNT_W_DEF = 20;
    localparam int N_MAX_DEF = 24;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD,
        EVAL,
        EXPAND,
        FINISH
    } state_t;

endpackage

// File: rtl/fib_sequencer.sv
// Computes fib(n) by walking the naive recursion tree on an external stack;
// every leaf adds its value to the result, every node bumps the call counter.
module fib_sequencer
    import fib_sequencer_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int RES_W = RES_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_MAX = N_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RES_W-1:0] result,
    output logic [CNT_W-1:0] calls,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [N_W-1:0]   stk_din,
    input  logic [N_W-1:0]   stk_dout,
    input  logic             stk_empty
);

    localparam logic [N_W-1:0] N_LIMIT = N_W'(N_MAX);
    localparam logic [N_W-1:0] TWO     = N_W'(2);
    localparam logic [N_W-1:0] ONE     = N_W'(1);

    state_t         state;
    logic [N_W-1:0] n_reg;
    logic [N_W-1:0] x2_reg;
    logic           leaf;

    assign leaf = (stk_dout < TWO);

    // Stack commands depend on the live top-of-stack so a node is consumed in
    // the same cycle it is inspected; they are suppressed while in reset.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = '0;
        if (rst_n) begin
            unique case (state)
                DRAIN: stk_pop = !stk_empty;
                LOAD: begin
                    stk_push = 1'b1;
                    stk_din  = n_reg;
                end
                EVAL: begin
                    if (!stk_empty) begin
                        if (leaf) begin
                            stk_pop = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            stk_pop  = 1'b1;
                            stk_din  = stk_dout - ONE;
                        end
                    end
                end
                EXPAND: begin
                    stk_push = 1'b1;
                    stk_din  = x2_reg;
                end
                default: ;
            endcase
        end
    end

    // busy and done are registered alongside the state so that busy tracks
    // "not IDLE" and done is high exactly while in FINISH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            calls  <= '0;
            n_reg  <= '0;
            x2_reg <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        result <= '0;
                        calls  <= '0;
                        if (n > N_LIMIT) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            err   <= 1'b0;
                            n_reg <= n;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (stk_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: state <= EVAL;
                EVAL: begin
                    if (stk_empty) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (leaf) begin
                        result <= result + RES_W'(stk_dout);
                        calls  <= calls + CNT_W'(1);
                    end else begin
                        x2_reg <= stk_dout - TWO;
                        calls  <= calls + CNT_W'(1);
                        state  <= EXPAND;
                    end
                end
                EXPAND: state <= EVAL;
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench for fib_sequencer with a behavioural 32-entry stack that
// records depth, command activity and over/underflow.
module tb_fib_sequencer;

    localparam int N_W   = 8;
    localparam int RES_W = 16;
    localparam int CNT_W = 20;
    localparam int N_MAX = 24;

    typedef struct {
        logic [N_W-1:0]   n;
        logic [RES_W-1:0] res;
        logic [CNT_W-1:0] calls;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [N_W-1:0]   n = '0;
    logic             busy, done, err;
    logic [RES_W-1:0] result;
    logic [CNT_W-1:0] calls;
    logic             stk_push, stk_pop;
    logic [N_W-1:0]   stk_din, stk_dout;
    logic             stk_empty;

    logic [N_W-1:0] mem [32];
    logic [5:0]     sp = '0;
    logic [5:0]     max_depth = '0;
    logic [6:0]     load_depth = 7'h7f;
    int             cmd_cycles = 0;
    logic           ovf = 1'b0, unf = 1'b0;
    int             run_id = 0;
    int             seen_id = 0;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    fib_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n),
        .busy(busy), .done(done), .err(err), .result(result), .calls(calls),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    assign stk_empty = (sp == 6'd0);
    assign stk_dout  = (sp == 6'd0) ? '0 : mem[5'(sp - 6'd1)];

    // Stack model; per-run statistics restart whenever run_id changes.
    always @(posedge clk) begin
        logic [5:0] nsp;
        logic [5:0] md;
        logic [6:0] ld;
        int         cc;
        nsp = sp;
        md  = (run_id != seen_id) ? 6'd0 : max_depth;
        ld  = (run_id != seen_id) ? 7'h7f : load_depth;
        cc  = (run_id != seen_id) ? 0 : cmd_cycles;
        seen_id <= run_id;
        if (stk_push || stk_pop) cc++;
        if (ld == 7'h7f && stk_push && !stk_pop) ld = {1'b0, sp};
        if (stk_push && stk_pop) begin
            if (sp == 6'd0) unf <= 1'b1;
            else mem[5'(sp - 6'd1)] <= stk_din;
        end else if (stk_push) begin
            if (sp == 6'd32) ovf <= 1'b1;
            else begin
                mem[5'(sp)] <= stk_din;
                nsp = sp + 6'd1;
            end
        end else if (stk_pop) begin
            if (sp == 6'd0) unf <= 1'b1;
            else nsp = sp - 6'd1;
        end
        if (nsp > md) md = nsp;
        sp         <= nsp;
        max_depth  <= md;
        load_depth <= ld;
        cmd_cycles <= cc;
    end

    function automatic exp_t model(input logic [N_W-1:0] nv);
        exp_t e;
        int f0, f1, c0, c1, t;
        e.n = nv;
        if (int'(nv) > N_MAX) begin
            e.err = 1'b1; e.res = '0; e.calls = '0;
            return e;
        end
        f0 = 0; f1 = 1; c0 = 1; c1 = 1;
        for (int i = 0; i < int'(nv); i++) begin
            t = f0 + f1; f0 = f1; f1 = t;
            t = 1 + c0 + c1; c0 = c1; c1 = t;
        end
        e.err   = 1'b0;
        e.res   = RES_W'(f0);
        e.calls = CNT_W'(c0);
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [N_W-1:0] nv);
        @(negedge clk);
        n = nv;
        start = 1'b1;
        run_id++;
        sb.push_back(model(nv));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int budget);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_timeout: done observed 0 expected 1 within %0d cycles", tag, budget);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checkValue({tag, "_result"}, 32'(result), 32'(e.res));
        checkValue({tag, "_calls"}, 32'(calls), 32'(e.calls));
        checkValue({tag, "_err"}, 32'(err), 32'(e.err));
        checkValue({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkValue({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkValue({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkValue({tag, "_result_held"}, 32'(result), 32'(e.res));
    endtask

    task automatic checkResetState(input string tag);
        checkValue({tag, "_busy"}, 32'(busy), 32'd0);
        checkValue({tag, "_done"}, 32'(done), 32'd0);
        checkValue({tag, "_err"}, 32'(err), 32'd0);
        checkValue({tag, "_result"}, 32'(result), 32'd0);
        checkValue({tag, "_calls"}, 32'(calls), 32'd0);
        checkValue({tag, "_cmd"}, {30'd0, stk_push, stk_pop}, 32'd0);
        checkValue({tag, "_din"}, 32'(stk_din), 32'd0);
    endtask

    initial begin
        $display("[TB] fib_sequencer bench starting");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        applyStimulus(8'd0);
        checkOutput("n0", 100);
        checkValue("n0_load_depth", 32'(load_depth), 32'd0);

        applyStimulus(8'd1);
        checkOutput("n1", 100);

        applyStimulus(8'd10);
        repeat (20) @(negedge clk);
        checkValue("n10_busy_mid", 32'(busy), 32'd1);
        n = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("n10", 2000);
        checkValue("n10_depth_le_11", 32'(max_depth <= 6'd11), 32'd1);

        applyStimulus(8'd24);
        checkOutput("n24", 250000);
        checkValue("n24_no_overflow", {30'd0, ovf, unf}, 32'd0);

        applyStimulus(8'd25);
        checkOutput("n25", 20);
        checkValue("n25_no_stack_cmd", 32'(cmd_cycles), 32'd0);

        applyStimulus(8'd20);
        repeat (500) @(negedge clk);
        checkValue("n20_busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        rst_n = 1'b1;
        sb.delete();
        checkValue("stale_stack_present", 32'(stk_empty), 32'd0);

        applyStimulus(8'd5);
        checkOutput("n5", 2000);
        checkValue("n5_drained_before_load", 32'(load_depth), 32'd0);
        checkValue("n5_stack_empty", 32'(stk_empty), 32'd1);
        checkValue("final_no_over_under", {30'd0, ovf, unf}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
